// File: rtl/detect_sched_if.sv
// ---------------------------------------------------------------------------
// detect_sched_if
// Requester-side bus of the detect_sched round-robin scheduler.
//
// Signals
//   req       N     per-requester job request (level)
//   data      N*W   requester i word at data[i*W +: W]
//   gnt       N     one-hot grant, high for the whole job
//   done      1     one-cycle job-complete pulse
//   done_id   IW    index of the completed requester
//   hit_cnt   CW    detector hits counted in the last job
//   first_hit 1     (HIT_POS_EN only) any hit occurred in the last job
//   first_pos PW    (HIT_POS_EN only) SHIFT cycle index of the earliest hit
//
// Modports
//   master : the requester side, drives req/data
//   slave  : the scheduler, drives grant and completion signals
//
// Optional feature macro: HIT_POS_EN
// ---------------------------------------------------------------------------
interface detect_sched_if #(
    parameter int N  = 4,
    parameter int IW = 2,
    parameter int W  = 8,
    parameter int CW = 4,
    parameter int PW = (W > 1) ? $clog2(W) : 1
);
    logic [N-1:0]   req;
    logic [N*W-1:0] data;
    logic [N-1:0]   gnt;
    logic           done;
    logic [IW-1:0]  done_id;
    logic [CW-1:0]  hit_cnt;
`ifdef HIT_POS_EN
    logic           first_hit;
    logic [PW-1:0]  first_pos;

    modport master (
        output req, data,
        input  gnt, done, done_id, hit_cnt, first_hit, first_pos
    );

    modport slave (
        input  req, data,
        output gnt, done, done_id, hit_cnt, first_hit, first_pos
    );
`else
    modport master (
        output req, data,
        input  gnt, done, done_id, hit_cnt
    );

    modport slave (
        input  req, data,
        output gnt, done, done_id, hit_cnt
    );
`endif
endinterface

// File: rtl/detect_sched.sv
// ---------------------------------------------------------------------------
// detect_sched
// Round-robin scheduler that shares one bit-serial Mealy sequence detector
// between N requesters. A granted requester's W-bit word is captured, the
// detector is cleared, the word is streamed MSB-first on fsm_x and the hits
// reported on fsm_y are counted. Each job ends with a done pulse carrying the
// requester id and the hit count.
//
// Ports
//   clk       in   1    clock, rising edge
//   nrst      in   1    asynchronous active-low reset
//   bus       slave modport of detect_sched_if (req, data, gnt, done,
//                  done_id, hit_cnt, and first_hit/first_pos with HIT_POS_EN)
//   fsm_x     out  1    serial bit to the detector
//   fsm_y     in   1    detector Mealy output (combinational from fsm_x)
//   fsm_nrst  out  1    detector reset, active low
//
// Optional feature macro: HIT_POS_EN (adds first_hit / first_pos tracking)
// ---------------------------------------------------------------------------
module detect_sched #(
    parameter int N  = 4,
    parameter int IW = 2,
    parameter int W  = 8,
    parameter int CW = 4
) (
    input  logic           clk,
    input  logic           nrst,
    detect_sched_if.slave  bus,
    output logic           fsm_x,
    input  logic           fsm_y,
    output logic           fsm_nrst
);

    localparam int BW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLR   = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t         state;
    logic [IW-1:0]  ptr;
    logic [IW-1:0]  gid;
    logic [BW-1:0]  bitcnt;
    logic [W-1:0]   shreg;

    logic           found;
    logic [IW-1:0]  sel;
    logic [IW-1:0]  cand;
    logic [IW-1:0]  nextptr;

    // Round-robin pick: walk the requesters starting at the pointer and
    // wrapping past N-1 back to 0; the first active request wins. There is
    // no fixed priority, only the rotating start point.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        cand  = '0;
        for (int i = 0; i < N; i++) begin
            cand = IW'((int'(ptr) + i) % N);
            if (!found && bus.req[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    // After a job the search restarts just past the requester that was
    // served, so a requester that keeps asking goes to the back of the line.
    always_comb begin
        nextptr = (gid == IW'(N - 1)) ? '0 : gid + 1'b1;
    end

    // Job sequencer. Every output is a register: the word is captured at
    // grant, the detector is held in reset for one CLR cycle, then W SHIFT
    // cycles present one bit each while fsm_y is sampled at the closing edge
    // of each cycle. The final SHIFT edge raises done and drops the grant at
    // once, so the DONE cycle is the single cycle carrying the done pulse.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state        <= IDLE;
            ptr          <= '0;
            gid          <= '0;
            bitcnt       <= '0;
            shreg        <= '0;
            fsm_x        <= 1'b0;
            fsm_nrst     <= 1'b0;
            bus.gnt      <= '0;
            bus.done     <= 1'b0;
            bus.done_id  <= '0;
            bus.hit_cnt  <= '0;
`ifdef HIT_POS_EN
            bus.first_hit <= 1'b0;
            bus.first_pos <= '0;
`endif
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    fsm_nrst <= 1'b0;
                    fsm_x    <= 1'b0;
                    if (found) begin
                        bus.gnt     <= N'(1) << sel;
                        gid         <= sel;
                        shreg       <= bus.data[int'(sel)*W +: W];
                        bus.hit_cnt <= '0;
`ifdef HIT_POS_EN
                        bus.first_hit <= 1'b0;
                        bus.first_pos <= '0;
`endif
                        state       <= CLR;
                    end
                end
                CLR: begin
                    // Detector has been reset for a full cycle; release it
                    // together with the MSB of the captured word.
                    fsm_nrst <= 1'b1;
                    fsm_x    <= shreg[W-1];
                    shreg    <= shreg << 1;
                    bitcnt   <= '0;
                    state    <= SHIFT;
                end
                SHIFT: begin
                    if (fsm_y) begin
                        bus.hit_cnt <= bus.hit_cnt + 1'b1;
                    end
`ifdef HIT_POS_EN
                    if (fsm_y && !bus.first_hit) begin
                        bus.first_hit <= 1'b1;
                        bus.first_pos <= bitcnt;
                    end
`endif
                    if (bitcnt == BW'(W - 1)) begin
                        fsm_nrst    <= 1'b0;
                        fsm_x       <= 1'b0;
                        bus.gnt     <= '0;
                        bus.done    <= 1'b1;
                        bus.done_id <= gid;
                        ptr         <= nextptr;
                        state       <= DONE;
                    end else begin
                        fsm_x  <= shreg[W-1];
                        shreg  <= shreg << 1;
                        bitcnt <= bitcnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_detect_sched.sv
// ---------------------------------------------------------------------------
// tb_detect_sched
// Self-checking bench for detect_sched. The shared detector is modelled here
// in one of two modes: echo (fsm_y = fsm_x) or a "101" overlapping Mealy
// detector. Expected grants, bit streams and hit counts come from a
// behavioural reference built on the scheduling rules and plain arithmetic.
// ---------------------------------------------------------------------------
module tb_detect_sched;

    localparam int N  = 4;
    localparam int IW = 2;
    localparam int W  = 8;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic nrst;
    logic fsm_x;
    logic fsm_y;
    logic fsm_nrst;

    int   checks    = 0;
    int   errors    = 0;
    int   cycle     = 0;
    int   rrPtr     = 0;
    int   lastGrant = 0;
    bit   detMode   = 1'b0;
    logic [1:0] hist;

    detect_sched_if #(.N(N), .IW(IW), .W(W), .CW(CW)) bus ();

    detect_sched #(.N(N), .IW(IW), .W(W), .CW(CW)) dut (
        .clk      (clk),
        .nrst     (nrst),
        .bus      (bus),
        .fsm_x    (fsm_x),
        .fsm_y    (fsm_y),
        .fsm_nrst (fsm_nrst)
    );

    // Free-running clock with a 10-unit period
    always #5 clk = ~clk;

    // Cycle counter used to measure grant-to-grant spacing
    always @(posedge clk) cycle <= cycle + 1;

    // Detector model: two-bit history cleared by fsm_nrst; in mode 1 it
    // reports a hit when the last two bits were 1,0 and the current bit is 1
    always_ff @(posedge clk or negedge fsm_nrst) begin
        if (!fsm_nrst) hist <= 2'b00;
        else           hist <= {hist[0], fsm_x};
    end

    assign fsm_y = detMode ? ((hist == 2'b10) && fsm_x) : fsm_x;

    // Safety net so the bench can never hang
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference arbiter: first set request scanning upward from the pointer
    function automatic int arbRef(input logic [N-1:0] r, input int p);
        for (int i = 0; i < N; i++) begin
            if (r[(p + i) % N]) return (p + i) % N;
        end
        return -1;
    endfunction

    // Reference hit count for a word streamed MSB-first
    function automatic int refHits(input logic [W-1:0] w, input bit m);
        int c = 0;
        bit s [W];
        for (int k = 0; k < W; k++) s[k] = w[W-1-k];
        for (int k = 0; k < W; k++) begin
            if (!m) begin
                if (s[k]) c++;
            end else if (k >= 2) begin
                if (s[k-2] && !s[k-1] && s[k]) c++;
            end
        end
        return c;
    endfunction

    // Reference position of the earliest hit, -1 when there is none
    function automatic int refFirst(input logic [W-1:0] w, input bit m);
        bit s [W];
        for (int k = 0; k < W; k++) s[k] = w[W-1-k];
        for (int k = 0; k < W; k++) begin
            if (!m) begin
                if (s[k]) return k;
            end else if (k >= 2) begin
                if (s[k-2] && !s[k-1] && s[k]) return k;
            end
        end
        return -1;
    endfunction

    function automatic logic [N*W-1:0] randData();
        logic [N*W-1:0] r;
        for (int i = 0; i < N; i++) r[i*W +: W] = W'($urandom);
        return r;
    endfunction

    function automatic logic [N*W-1:0] putWord(input logic [N*W-1:0] base,
                                               input int id,
                                               input logic [W-1:0] w);
        logic [N*W-1:0] r;
        r = base;
        r[id*W +: W] = w;
        return r;
    endfunction

    task automatic applyStimulus(input logic [N-1:0] r,
                                 input logic [N*W-1:0] d,
                                 input bit m);
        bus.req  = r;
        bus.data = d;
        detMode  = m;
    endtask

    task automatic checkOutput(input string tag,
                               input logic [31:0] obs,
                               input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs one complete job against the reference: waits for the grant,
    // follows CLR, the W SHIFT cycles and DONE, then sets up the next
    // request pattern during DONE and checks the following idle cycle.
    task automatic doJob(input int expLat, input int expGap, input bit churn,
                         input logic [N-1:0] nextReq,
                         input logic [N*W-1:0] nextData,
                         input bit nextMode);
        int expId;
        int expHits;
        int expFirst;
        int lat;
        bit seen;
        logic [W-1:0] word;

        expId = arbRef(bus.req, rrPtr);
        if (expId < 0) expId = 0;
        word     = bus.data[expId*W +: W];
        expHits  = refHits(word, detMode);
        expFirst = refFirst(word, detMode);

        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 40) begin
            @(negedge clk);
            lat++;
            seen = (bus.gnt != '0);
        end
        checkOutput("grant_seen", 32'(seen), 32'd1);
        if (!seen) return;
        if (expLat > 0) checkOutput("grant_latency", lat, expLat);
        if (expGap > 0) checkOutput("grant_spacing", cycle - lastGrant, expGap);
        lastGrant = cycle;

        checkOutput("gnt_onehot", 32'(bus.gnt), 32'(1) << expId);
        checkOutput("clr_fsm_nrst", 32'(fsm_nrst), 32'd0);
        checkOutput("clr_hit_cnt", 32'(bus.hit_cnt), 32'd0);
`ifdef HIT_POS_EN
        checkOutput("clr_first_hit", 32'(bus.first_hit), 32'd0);
`endif

        for (int k = 0; k < W; k++) begin
            @(negedge clk);
            checkOutput("shift_fsm_nrst", 32'(fsm_nrst), 32'd1);
            checkOutput("shift_fsm_x", 32'(fsm_x), 32'(word[W-1-k]));
            checkOutput("shift_gnt", 32'(bus.gnt), 32'(1) << expId);
            checkOutput("shift_done", 32'(bus.done), 32'd0);
            bus.data = randData();
            if (churn) bus.req = N'($urandom);
        end

        @(negedge clk);
        checkOutput("done_pulse", 32'(bus.done), 32'd1);
        checkOutput("done_id", 32'(bus.done_id), expId);
        checkOutput("hit_cnt", 32'(bus.hit_cnt), expHits);
        checkOutput("done_gnt", 32'(bus.gnt), 32'd0);
        checkOutput("done_fsm_nrst", 32'(fsm_nrst), 32'd0);
`ifdef HIT_POS_EN
        checkOutput("first_hit", 32'(bus.first_hit), (expFirst >= 0) ? 32'd1 : 32'd0);
        checkOutput("first_pos", 32'(bus.first_pos), (expFirst >= 0) ? 32'(expFirst) : 32'd0);
`else
        if (expFirst > W) $display("[TB] unexpected first-hit index %0d", expFirst);
`endif
        rrPtr = (expId + 1) % N;
        applyStimulus(nextReq, nextData, nextMode);

        @(negedge clk);
        checkOutput("idle_done", 32'(bus.done), 32'd0);
        checkOutput("idle_done_id_held", 32'(bus.done_id), expId);
        checkOutput("idle_hit_cnt_held", 32'(bus.hit_cnt), expHits);
    endtask

    // Directed scenarios first, then a randomized run against the reference
    initial begin
        int  lat;
        bit  seen;
        int  doneSeen;

        nrst = 1'b0;
        applyStimulus('0, '0, 1'b0);
        repeat (3) @(negedge clk);

        $display("[TB] reset state");
        checkOutput("rst_gnt", 32'(bus.gnt), 32'd0);
        checkOutput("rst_done", 32'(bus.done), 32'd0);
        checkOutput("rst_done_id", 32'(bus.done_id), 32'd0);
        checkOutput("rst_hit_cnt", 32'(bus.hit_cnt), 32'd0);
        checkOutput("rst_fsm_x", 32'(fsm_x), 32'd0);
        checkOutput("rst_fsm_nrst", 32'(fsm_nrst), 32'd0);
`ifdef HIT_POS_EN
        checkOutput("rst_first_hit", 32'(bus.first_hit), 32'd0);
        checkOutput("rst_first_pos", 32'(bus.first_pos), 32'd0);
`endif
        nrst = 1'b1;

        $display("[TB] single requester, word B2");
        applyStimulus(4'b0001, putWord(randData(), 0, 8'hB2), 1'b0);
        doJob(1, 0, 1'b0, 4'b0000, randData(), 1'b0);
        repeat (2) @(negedge clk);
        checkOutput("idle_no_grant", 32'(bus.gnt), 32'd0);

        $display("[TB] pointer rotation after id 1");
        applyStimulus(4'b0010, randData(), 1'b0);
        doJob(1, 0, 1'b0, 4'b1010, randData(), 1'b0);
        doJob(1, W + 3, 1'b0, 4'b1010, randData(), 1'b0);
        doJob(1, W + 3, 1'b0, 4'b0000, randData(), 1'b0);

        $display("[TB] all-zero, all-one and 20 words");
        applyStimulus(4'b0100, putWord(randData(), 2, 8'h00), 1'b0);
        doJob(1, 0, 1'b0, 4'b0100, putWord(randData(), 2, 8'hFF), 1'b0);
        doJob(1, W + 3, 1'b0, 4'b0100, putWord(randData(), 2, 8'h20), 1'b0);
        doJob(1, W + 3, 1'b0, 4'b0000, randData(), 1'b0);

        $display("[TB] reset during SHIFT");
        applyStimulus(4'b1111, {(N*W){1'b1}}, 1'b0);
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 40) begin
            @(negedge clk);
            lat++;
            seen = (bus.gnt != '0);
        end
        checkOutput("abort_grant_seen", 32'(seen), 32'd1);
        repeat (4) @(negedge clk);
        checkOutput("abort_pre_fsm_x", 32'(fsm_x), 32'd1);
        nrst = 1'b0;
        #1;
        checkOutput("abort_gnt", 32'(bus.gnt), 32'd0);
        checkOutput("abort_done", 32'(bus.done), 32'd0);
        checkOutput("abort_done_id", 32'(bus.done_id), 32'd0);
        checkOutput("abort_hit_cnt", 32'(bus.hit_cnt), 32'd0);
        checkOutput("abort_fsm_x", 32'(fsm_x), 32'd0);
        checkOutput("abort_fsm_nrst", 32'(fsm_nrst), 32'd0);
        doneSeen = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (bus.done) doneSeen++;
        end
        checkOutput("abort_no_done", doneSeen, 0);
        @(negedge clk);
        nrst  = 1'b1;
        rrPtr = 0;

        $display("[TB] all requesting, round-robin order");
        doJob(1, 0, 1'b0, 4'b1111, randData(), 1'b0);
        doJob(1, W + 3, 1'b0, 4'b1111, randData(), 1'b0);
        doJob(1, W + 3, 1'b0, 4'b1111, randData(), 1'b0);
        doJob(1, W + 3, 1'b0, 4'b1111, randData(), 1'b0);
        doJob(1, W + 3, 1'b0, N'($urandom_range(1, (1 << N) - 1)), randData(), 1'b1);

        $display("[TB] randomized jobs");
        for (int j = 0; j < 20; j++) begin
            doJob(1, W + 3, 1'b1, N'($urandom_range(1, (1 << N) - 1)),
                  randData(), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
